// File: rtl/judge_pkg.sv
// Shared types and constants for the hit/miss judging block.
// Lane state encoding, lane count and the default window length live here.
package judge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } lane_state_t;

    localparam int NUM_LANES      = 4;
    localparam int WIN_FRAMES_DEF = 6;

    // Bits needed to hold a window count of 0..n.
    function automatic int win_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/judge_lane.sv
// One judging lane: key synchronizer and press detect, IDLE/OPEN window FSM,
// and the saturating per-frame hit/miss accumulators with their output registers.
module judge_lane
    import judge_pkg::*;
#(
    parameter int WIN_FRAMES     = WIN_FRAMES_DEF,
    parameter bit PENALIZE_STRAY = 1'b1,
    parameter int CNT_W          = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             frame_edge_i,
    input  logic             game_active_i,
    input  logic             note_due_i,
    input  logic             key_i,
    output logic [CNT_W-1:0] hit_o,
    output logic [CNT_W-1:0] miss_o,
    output lane_state_t      state_o
);

    localparam int              WIN_W    = win_width(WIN_FRAMES);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WIN_FRAMES);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    logic key_s1_q, key_s2_q, key_prev_q;
    logic press;
    logic note_ok, press_ok;

    lane_state_t      state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             hit_ev, miss_ev;

    logic [CNT_W-1:0] hit_acc_q, hit_acc_d;
    logic [CNT_W-1:0] miss_acc_q, miss_acc_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    // Key levels are fully asynchronous; two flops before the edge detect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_s1_q   <= 1'b0;
            key_s2_q   <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            key_s1_q   <= key_i;
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
        end
    end

    assign press    = key_s2_q & ~key_prev_q;
    assign note_ok  = note_due_i & game_active_i;
    assign press_ok = press & game_active_i;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        hit_ev  = 1'b0;
        miss_ev = 1'b0;
        if (!game_active_i) begin
            state_d = IDLE;
            win_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_ok && PENALIZE_STRAY) begin
                        miss_ev = 1'b1;
                    end
                    if (note_ok) begin
                        state_d = OPEN;
                        win_d   = WIN_LOAD;
                    end
                end
                OPEN: begin
                    // A press always closes the current window as a hit, even on its expiring edge.
                    if (press_ok) begin
                        hit_ev = 1'b1;
                        if (note_ok) begin
                            win_d = WIN_LOAD;
                        end else begin
                            state_d = IDLE;
                            win_d   = '0;
                        end
                    end else if (note_ok) begin
                        miss_ev = 1'b1;
                        win_d   = WIN_LOAD;
                    end else if (frame_edge_i) begin
                        if (win_q <= WIN_ONE) begin
                            miss_ev = 1'b1;
                            state_d = IDLE;
                            win_d   = '0;
                        end else begin
                            win_d = win_q - WIN_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    win_d   = '0;
                end
            endcase
        end
    end

    // On a frame edge the finished frame moves to the outputs and the accumulator
    // restarts with whatever was recorded in that same cycle.
    always_comb begin
        hit_d      = hit_q;
        miss_d     = miss_q;
        hit_acc_d  = sat_inc(hit_acc_q, hit_ev);
        miss_acc_d = sat_inc(miss_acc_q, miss_ev);
        if (frame_edge_i) begin
            hit_d      = hit_acc_q;
            miss_d     = miss_acc_q;
            hit_acc_d  = CNT_W'(hit_ev);
            miss_acc_d = CNT_W'(miss_ev);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            win_q      <= '0;
            hit_acc_q  <= '0;
            miss_acc_q <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            hit_acc_q  <= hit_acc_d;
            miss_acc_q <= miss_acc_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign hit_o   = hit_q;
    assign miss_o  = miss_q;
    assign state_o = state_q;

endmodule

// File: rtl/hit_judge.sv
// Four-lane hit/miss judge: frame boundary detect shared by all lanes,
// per-lane judging, and fan-out of the per-frame counts to flat ports.
module hit_judge
    import judge_pkg::*;
#(
    parameter int WIN_FRAMES     = WIN_FRAMES_DEF,
    parameter bit PENALIZE_STRAY = 1'b1,
    parameter int CNT_W          = 4
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    input  logic                 frame_clk,
    input  logic                 game_active,
    input  logic [NUM_LANES-1:0] note_due,
    input  logic [NUM_LANES-1:0] key,
    output logic [CNT_W-1:0]     hit0,
    output logic [CNT_W-1:0]     hit1,
    output logic [CNT_W-1:0]     hit2,
    output logic [CNT_W-1:0]     hit3,
    output logic [CNT_W-1:0]     miss0,
    output logic [CNT_W-1:0]     miss1,
    output logic [CNT_W-1:0]     miss2,
    output logic [CNT_W-1:0]     miss3,
    output logic [NUM_LANES-1:0] lane_open
);

    logic frame_clk_q;
    logic frame_edge;

    logic [CNT_W-1:0] hit_w  [NUM_LANES];
    logic [CNT_W-1:0] miss_w [NUM_LANES];
    lane_state_t      state_w[NUM_LANES];

    // Same single-register edge detect as the score accumulator, so both see one edge cycle.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_clk_q <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
        end
    end

    assign frame_edge = frame_clk & ~frame_clk_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        judge_lane #(
            .WIN_FRAMES    (WIN_FRAMES),
            .PENALIZE_STRAY(PENALIZE_STRAY),
            .CNT_W         (CNT_W)
        ) u_lane (
            .clk_i        (Clk),
            .rst_ni       (reset_n),
            .frame_edge_i (frame_edge),
            .game_active_i(game_active),
            .note_due_i   (note_due[i]),
            .key_i        (key[i]),
            .hit_o        (hit_w[i]),
            .miss_o       (miss_w[i]),
            .state_o      (state_w[i])
        );

        assign lane_open[i] = (state_w[i] == OPEN);
    end

    assign hit0  = hit_w[0];
    assign hit1  = hit_w[1];
    assign hit2  = hit_w[2];
    assign hit3  = hit_w[3];
    assign miss0 = miss_w[0];
    assign miss1 = miss_w[1];
    assign miss2 = miss_w[2];
    assign miss3 = miss_w[3];

endmodule
